ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_pkg.sv | 103 ++++++++++
 rtl/ctrl_seq_decode.sv | 140 ++++++++++++++
 rtl/ctrl_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq_pkg
// Purpose  : Shared definitions for the ctrl_seq instruction sequencer:
//            ALU operation codes, the phase enum, opcode field constants,
//            the control-strobe bundle and the instruction classifier.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_seq_pkg;

  // ALU operation codes driven on alu_sel
  localparam logic [5:0] ALU_A    = 6'd0;  // pass operand A
  localparam logic [5:0] ALU_B    = 6'd1;  // pass operand B (immediate / stack)
  localparam logic [5:0] ALU_ADD  = 6'd2;  // A + B
  localparam logic [5:0] ALU_ADDZ = 6'd3;  // A + B when top of stack is zero
  localparam logic [5:0] ALU_INC2 = 6'd4;  // A + 2 (instruction pointer step)
  localparam logic [5:0] ALU_NOT  = 6'd5;  // bitwise invert of A

  // Sequencer phases (binary encoded state register)
  typedef enum logic [1:0] {
    PH_FETCH  = 2'd0,
    PH_DECODE = 2'd1,
    PH_EXEC   = 2'd2,
    PH_RDMEM  = 2'd3
  } phase_e;

  // Bit positions inside the one-hot phase output {fetch, rdmem, exec, decode}
  localparam int PHB_DECODE = 0;
  localparam int PHB_EXEC   = 1;
  localparam int PHB_RDMEM  = 2;
  localparam int PHB_FETCH  = 3;

  // Opcode field constants
  localparam logic [3:0]  OP_JMP    = 4'h0;      // insn[15:12], bit0 set = CALL
  localparam logic [3:0]  OP_JZ     = 4'h1;      // insn[15:12]
  localparam logic [7:0]  OP_ST_FP  = 8'h34;     // insn[15:8], store at FP+offset
  localparam logic [15:0] OP_POP    = 16'h704F;
  localparam logic [15:0] OP_NOT    = 16'h7004;
  localparam logic [14:0] OP_LDD    = 15'h3C04;  // insn[15:1]: 0x7808/0x7809, bit0 = byte

  // Immediate masks before zero-extension to DATA_W
  localparam logic [11:0] MASK_JMP  = 12'hFFE;
  localparam logic [11:0] MASK_ST   = 12'h3FE;

  // Instruction classes recognised by the sequencer
  typedef enum logic [3:0] {
    IC_UNDEF = 4'd0,
    IC_PUSH  = 4'd1,
    IC_JMP   = 4'd2,
    IC_CALL  = 4'd3,
    IC_JZ    = 4'd4,
    IC_ST    = 4'd5,
    IC_POP   = 4'd6,
    IC_NOT   = 4'd7,
    IC_LDD   = 4'd8
  } iclass_e;

  // Single-bit datapath controls, packed in output-port order
  typedef struct packed {
    logic imm;
    logic src_a_stk0;
    logic src_a_fp;
    logic src_a_ip;
    logic src_a_cstk;
    logic wr_stk1;
    logic pop;
    logic push;
    logic load_stk;
    logic load_fp;
    logic load_ip;
    logic cpop;
    logic cpush;
    logic byt;
    logic rd_mem;
    logic wr_mem;
  } ctrl_t;

  // Map a latched instruction word onto its class. PUSH owns the whole
  // upper half of the opcode space, so bit15 is tested first.
  function automatic iclass_e classify(input logic [15:0] i);
    iclass_e c;
    c = IC_UNDEF;
    if (i[15]) begin
      c = IC_PUSH;
    end else if (i[15:12] == OP_JMP) begin
      c = i[0] ? IC_CALL : IC_JMP;
    end else if (i[15:12] == OP_JZ) begin
      c = IC_JZ;
    end else if (i[15:8] == OP_ST_FP) begin
      c = IC_ST;
    end else if (i == OP_POP) begin
      c = IC_POP;
    end else if (i == OP_NOT) begin
      c = IC_NOT;
    end else if (i[15:1] == OP_LDD) begin
      c = IC_LDD;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq_decode
// Purpose  : Purely combinational control decoder. Turns the current phase,
//            the latched instruction and the memory handshake into the
//            datapath control bundle, ALU select and immediate mask.
// Ports    : state        - current sequencer phase
//            insn_q       - latched instruction word
//            mem_ready    - effective memory-ready (already forced high when
//                           waits are disabled)
//            decode_first - high in the first cycle of a DECODE phase
//            strobe_en    - low forces every strobe off (reset)
//            ctl          - control bundle
//            alu_sel      - ALU operation code
//            imm_mask     - immediate field mask, DATA_W wide
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  phase_e              state,
  input  logic [15:0]         insn_q,
  input  logic                mem_ready,
  input  logic                decode_first,
  input  logic                strobe_en,
  output ctrl_t               ctl,
  output logic [5:0]          alu_sel,
  output logic [DATA_W-1:0]   imm_mask
);

  localparam logic [DATA_W-1:0] PUSH_MASK = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] JMP_MASK  = {{(DATA_W-12){1'b0}}, MASK_JMP};
  localparam logic [DATA_W-1:0] ST_MASK   = {{(DATA_W-12){1'b0}}, MASK_ST};

  iclass_e cls;

  assign cls = classify(insn_q);

  always_comb begin
    ctl      = '0;
    alu_sel  = ALU_A;
    imm_mask = '0;

    unique case (state)
      PH_FETCH: begin
        ctl.src_a_ip = 1'b1;
        alu_sel      = ALU_INC2;
        ctl.load_ip  = mem_ready;
      end

      PH_DECODE: begin
        // CALL saves the return address early; a stall must not push twice.
        if (cls == IC_CALL) begin
          ctl.src_a_ip = 1'b1;
          ctl.cpush    = decode_first;
        end
      end

      PH_EXEC: begin
        case (cls)
          IC_PUSH: begin
            ctl.imm      = 1'b1;
            imm_mask     = PUSH_MASK;
            alu_sel      = ALU_B;
            ctl.push     = 1'b1;
            ctl.load_stk = 1'b1;
          end
          IC_JMP, IC_CALL: begin
            ctl.imm      = 1'b1;
            imm_mask     = JMP_MASK;
            ctl.src_a_ip = 1'b1;
            alu_sel      = ALU_ADD;
            ctl.load_ip  = 1'b1;
          end
          IC_JZ: begin
            ctl.imm      = 1'b1;
            imm_mask     = JMP_MASK;
            ctl.src_a_ip = 1'b1;
            alu_sel      = ALU_ADDZ;
            ctl.load_ip  = 1'b1;
            ctl.pop      = 1'b1;
          end
          IC_ST: begin
            // Write request is held for the whole wait; the stack only
            // pops once the memory accepts the data.
            ctl.imm      = 1'b1;
            imm_mask     = ST_MASK;
            ctl.src_a_fp = 1'b1;
            alu_sel      = ALU_ADD;
            ctl.wr_mem   = 1'b1;
            ctl.pop      = mem_ready;
          end
          IC_POP: begin
            alu_sel      = ALU_B;
            ctl.pop      = 1'b1;
            ctl.load_stk = 1'b1;
          end
          IC_NOT: begin
            ctl.src_a_stk0 = 1'b1;
            alu_sel        = ALU_NOT;
            ctl.load_stk   = 1'b1;
          end
          IC_LDD: begin
            // Address goes out from top of stack; the load happens in RDMEM.
            ctl.src_a_stk0 = 1'b1;
            alu_sel        = ALU_A;
          end
          default: begin
          end
        endcase
      end

      PH_RDMEM: begin
        ctl.src_a_ip = 1'b1;
        alu_sel      = ALU_A;
        if (cls == IC_LDD) begin
          ctl.rd_mem   = 1'b1;
          ctl.byt      = insn_q[0];
          ctl.load_stk = mem_ready;
        end
      end
    endcase

    if (!strobe_en) begin
      ctl.load_stk = 1'b0;
      ctl.load_fp  = 1'b0;
      ctl.load_ip  = 1'b0;
      ctl.push     = 1'b0;
      ctl.pop      = 1'b0;
      ctl.cpush    = 1'b0;
      ctl.cpop     = 1'b0;
      ctl.rd_mem   = 1'b0;
      ctl.wr_mem   = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq
// Purpose  : Four-phase instruction sequencer (FETCH, DECODE, EXEC, RDMEM).
//            Holds the phase FSM and the latched instruction; the control
//            outputs are decoded combinationally from those and mem_ready.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            insn             - instruction word, sampled in FETCH on mem_ready
//            mem_ready        - memory access complete this cycle
//            stall            - hold DECODE while high
//            phase            - one-hot {fetch, rdmem, exec, decode}
//            imm .. wr_mem    - single-bit datapath controls
//            imm_mask         - immediate field mask (DATA_W bits)
//            alu_sel          - ALU operation code
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int WAIT_EN    = 1,
  parameter int SKIP_RDMEM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       insn,
  input  logic              mem_ready,
  input  logic              stall,
  output logic [3:0]        phase,
  output logic              imm,
  output logic              src_a_stk0,
  output logic              src_a_fp,
  output logic              src_a_ip,
  output logic              src_a_cstk,
  output logic              wr_stk1,
  output logic              pop,
  output logic              push,
  output logic              load_stk,
  output logic              load_fp,
  output logic              load_ip,
  output logic              cpop,
  output logic              cpush,
  output logic              byt,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DATA_W-1:0] imm_mask,
  output logic [5:0]        alu_sel
);

  phase_e      state;
  phase_e      state_nxt;
  logic [15:0] insn_q;
  logic        decode_seen;   // previous cycle was DECODE
  logic        rdy;
  iclass_e     cls;
  ctrl_t       ctl;

  // With waits disabled every access completes in the cycle it starts.
  assign rdy = (WAIT_EN != 0) ? mem_ready : 1'b1;
  assign cls = classify(insn_q);

  // --------------------------------------------------------------------------
  // State register and instruction latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PH_FETCH;
      insn_q      <= '0;
      decode_seen <= 1'b0;
    end else begin
      state       <= state_nxt;
      decode_seen <= (state == PH_DECODE);
      if (state == PH_FETCH && rdy) begin
        insn_q <= insn;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      PH_FETCH: begin
        if (rdy) state_nxt = PH_DECODE;
      end
      PH_DECODE: begin
        if (!stall) state_nxt = PH_EXEC;
      end
      PH_EXEC: begin
        // Only the store touches memory in EXEC and therefore waits here.
        if (cls == IC_ST && !rdy) begin
          state_nxt = PH_EXEC;
        end else if (cls == IC_LDD || SKIP_RDMEM == 0) begin
          state_nxt = PH_RDMEM;
        end else begin
          state_nxt = PH_FETCH;
        end
      end
      PH_RDMEM: begin
        if (cls != IC_LDD || rdy) state_nxt = PH_FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    phase = '0;
    unique case (state)
      PH_FETCH:  phase[PHB_FETCH]  = 1'b1;
      PH_DECODE: phase[PHB_DECODE] = 1'b1;
      PH_EXEC:   phase[PHB_EXEC]   = 1'b1;
      PH_RDMEM:  phase[PHB_RDMEM]  = 1'b1;
    endcase
  end

  // DECODE is only entered from FETCH, so decode_seen is low exactly in the
  // first DECODE cycle of each instruction. Reset gates the strobes
  // combinationally so nothing fires while rst is high.
  ctrl_seq_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .state        (state),
    .insn_q       (insn_q),
    .mem_ready    (rdy),
    .decode_first (!decode_seen),
    .strobe_en    (!rst),
    .ctl          (ctl),
    .alu_sel      (alu_sel),
    .imm_mask     (imm_mask)
  );

  assign imm        = ctl.imm;
  assign src_a_stk0 = ctl.src_a_stk0;
  assign src_a_fp   = ctl.src_a_fp;
  assign src_a_ip   = ctl.src_a_ip;
  assign src_a_cstk = ctl.src_a_cstk;
  assign wr_stk1    = ctl.wr_stk1;
  assign pop        = ctl.pop;
  assign push       = ctl.push;
  assign load_stk   = ctl.load_stk;
  assign load_fp    = ctl.load_fp;
  assign load_ip    = ctl.load_ip;
  assign cpop       = ctl.cpop;
  assign cpush      = ctl.cpush;
  assign byt        = ctl.byt;
  assign rd_mem     = ctl.rd_mem;
  assign wr_mem     = ctl.wr_mem;

endmodule
`default_nettype wire
